// File: rtl/face_core_scheduler.sv
// Frame dispatcher for the face-detection core array: validates a frame request,
// launches cores in index order under an active-core cap and tracks completions.
module face_core_scheduler #(
    parameter int NUM_CORES  = 36,
    parameter int MAX_ACTIVE = 8,
    parameter int ID_W       = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          size,
    output logic [31:0]          core_size,
    output logic                 core_mode,
    output logic [NUM_CORES-1:0] core_start,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 busy,
    output logic [ID_W-1:0]      active_cnt,
    output logic [ID_W-1:0]      done_cnt,
    output logic                 all_done,
    output logic                 err_size,
    output logic                 err_spurious
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_DISPATCH = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [ID_W-1:0]      CAP     = ID_W'(MAX_ACTIVE);
    localparam logic [ID_W-1:0]      LAST_ID = ID_W'(NUM_CORES - 1);
    localparam logic [NUM_CORES-1:0] ONE     = NUM_CORES'(1);

    logic [2:0]           state_q, state_d;
    logic [NUM_CORES-1:0] running_q, running_d;
    logic [ID_W-1:0]      next_id_q, next_id_d;
    logic [31:0]          core_size_q, core_size_d;
    logic                 core_mode_q, core_mode_d;
    logic [NUM_CORES-1:0] core_start_q, core_start_d;
    logic                 busy_q, busy_d;
    logic [ID_W-1:0]      active_q, active_d;
    logic [ID_W-1:0]      done_q, done_d;
    logic                 all_done_q, all_done_d;
    logic                 err_size_q, err_size_d;
    logic                 err_spur_q, err_spur_d;
    logic [NUM_CORES-1:0] hit, spur, launch;

    function automatic logic [ID_W-1:0] popcnt(input logic [NUM_CORES-1:0] v);
        logic [ID_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) n = n + ID_W'(v[i]);
        return n;
    endfunction

    always_comb begin
        state_d      = state_q;
        next_id_d    = next_id_q;
        core_size_d  = core_size_q;
        core_mode_d  = core_mode_q;
        core_start_d = '0;
        busy_d       = busy_q;
        all_done_d   = 1'b0;
        err_size_d   = err_size_q;
        err_spur_d   = err_spur_q;
        launch       = '0;
        // A done on a core that is only being launched this cycle sees running_q=0: spurious.
        hit          = core_done & running_q;
        spur         = core_done & ~running_q;
        done_d       = done_q + popcnt(hit);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_size_d = 1'b0;
                    err_spur_d = 1'b0;
                    if (size[2:0] == 3'd0 && size >= 32'd48) begin
                        core_size_d = size;
                        core_mode_d = 1'b0;
                        busy_d      = 1'b1;
                        done_d      = '0;
                        next_id_d   = '0;
                        state_d     = S_SETUP;
                    end else begin
                        err_size_d = 1'b1;
                    end
                end
            end
            S_SETUP: state_d = S_DISPATCH;
            S_DISPATCH: begin
                if (active_q < CAP) begin
                    launch       = ONE << next_id_q;
                    core_start_d = launch;
                    next_id_d    = next_id_q + ID_W'(1);
                    if (next_id_q == LAST_ID) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (running_q == '0) begin
                    all_done_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                busy_d      = 1'b0;
                core_mode_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (spur != '0) err_spur_d = 1'b1;
        running_d = (running_q & ~core_done) | launch;
        active_d  = popcnt(running_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            running_q    <= '0;
            next_id_q    <= '0;
            core_size_q  <= '0;
            core_mode_q  <= 1'b1;
            core_start_q <= '0;
            busy_q       <= 1'b0;
            active_q     <= '0;
            done_q       <= '0;
            all_done_q   <= 1'b0;
            err_size_q   <= 1'b0;
            err_spur_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            running_q    <= running_d;
            next_id_q    <= next_id_d;
            core_size_q  <= core_size_d;
            core_mode_q  <= core_mode_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            active_q     <= active_d;
            done_q       <= done_d;
            all_done_q   <= all_done_d;
            err_size_q   <= err_size_d;
            err_spur_q   <= err_spur_d;
        end
    end

    assign core_size    = core_size_q;
    assign core_mode    = core_mode_q;
    assign core_start   = core_start_q;
    assign busy         = busy_q;
    assign active_cnt   = active_q;
    assign done_cnt     = done_q;
    assign all_done     = all_done_q;
    assign err_size     = err_size_q;
    assign err_spurious = err_spur_q;
endmodule

// File: tb/tb_face_core_scheduler.sv
// Directed bench for face_core_scheduler: default instance with a latency-driven core
// model, plus a MAX_ACTIVE=1 instance whose cores finish in zero cycles.
module tb_face_core_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] size = '0;
    logic [31:0] core_size;
    logic        core_mode, busy, all_done, err_size, err_spurious;
    logic [35:0] core_start, core_done, model_done;
    logic [35:0] inj_done = '0;
    logic [5:0]  active_cnt, done_cnt;

    logic        start1 = 1'b0;
    logic [31:0] size1 = '0;
    logic [31:0] core_size1;
    logic        core_mode1, busy1, all_done1, err_size1, err_spurious1;
    logic [35:0] core_start1, core_done1;
    logic [5:0]  active_cnt1, done_cnt1;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int n_launch = 0, n_multi = 0, n_over = 0, n_ad = 0;
    int n_launch1 = 0, n_over1 = 0, n_ad1 = 0;
    int launch_cyc[36];
    int launch_cyc1[36];

    logic        hold = 1'b0;
    int          lat = 1;
    logic [35:0] manual_mask = '0;
    logic [35:0] held = '0;
    int          tmr[36];

    face_core_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .size(size),
        .core_size(core_size), .core_mode(core_mode), .core_start(core_start),
        .core_done(core_done), .busy(busy), .active_cnt(active_cnt),
        .done_cnt(done_cnt), .all_done(all_done), .err_size(err_size),
        .err_spurious(err_spurious)
    );

    face_core_scheduler #(.MAX_ACTIVE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .size(size1),
        .core_size(core_size1), .core_mode(core_mode1), .core_start(core_start1),
        .core_done(core_done1), .busy(busy1), .active_cnt(active_cnt1),
        .done_cnt(done_cnt1), .all_done(all_done1), .err_size(err_size1),
        .err_spurious(err_spurious1)
    );

    assign core_done  = model_done | inj_done;
    assign core_done1 = core_start1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: done is seen `lat` edges after the launch edge; `hold` parks cores.
    always @(negedge clk) begin
        model_done = '0;
        if (reset) begin
            held = '0;
            for (int i = 0; i < 36; i++) tmr[i] = 0;
        end else begin
            for (int i = 0; i < 36; i++) begin
                if (tmr[i] == 1) begin
                    model_done[i] = 1'b1;
                    tmr[i] = 0;
                end else if (tmr[i] > 1) begin
                    tmr[i] = tmr[i] - 1;
                end
            end
            if (!hold && held != '0) begin
                model_done = model_done | (held & ~manual_mask);
                held = '0;
            end
            for (int i = 0; i < 36; i++) begin
                if (core_start[i]) begin
                    if (hold) held[i] = 1'b1;
                    else if (lat <= 1) model_done[i] = 1'b1;
                    else tmr[i] = lat - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (core_start != '0) begin
                n_launch++;
                if ($countones(core_start) != 1) n_multi++;
                for (int i = 0; i < 36; i++) if (core_start[i]) launch_cyc[i] = cyc;
            end
            if (active_cnt > 6'd8) n_over++;
            if (all_done) n_ad++;
            if (core_start1 != '0) begin
                n_launch1++;
                for (int i = 0; i < 36; i++) if (core_start1[i]) launch_cyc1[i] = cyc;
            end
            if (active_cnt1 > 6'd1) n_over1++;
            if (all_done1) n_ad1++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] sz, output int t);
        @(negedge clk);
        size  = sz;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = cyc;
    endtask

    task automatic wait_done0(input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (all_done) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, at, nbad, ad0;
        repeat (2) @(negedge clk);
        check("rst_core_size", core_size, 0);
        check("rst_core_mode", core_mode, 1);
        check("rst_core_start", core_start, 0);
        check("rst_busy", busy, 0);
        check("rst_active", active_cnt, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_all_done", all_done, 0);
        check("rst_err_size", err_size, 0);
        check("rst_err_spur", err_spurious, 0);
        reset = 1'b0;

        // Rejected sizes, then a valid frame with 20-cycle cores
        pulse_start(32'd40, t);
        check("rej40_err", err_size, 1);
        check("rej40_busy", busy, 0);
        pulse_start(32'd100, t);
        check("rej100_err", err_size, 1);
        check("rej100_busy", busy, 0);
        check("rej100_mode", core_mode, 1);
        @(negedge clk);
        check("rej_no_launch", n_launch, 0);
        lat = 20;
        ad0 = n_ad;
        pulse_start(32'd64, t);
        check("acc_err_clr", err_size, 0);
        check("acc_busy", busy, 1);
        check("acc_core_size", core_size, 64);
        check("acc_mode", core_mode, 0);
        repeat (9) @(negedge clk);
        check("cap_reached", active_cnt, 8);
        repeat (8) @(negedge clk);
        check("cap_hold", active_cnt, 8);
        check("cap_stall", core_start, 0);
        wait_done0(300, at);
        check("f1_alldone_cyc", at, t + 110);
        check("f1_done_cnt", done_cnt, 36);
        repeat (2) @(negedge clk);
        check("f1_busy_off", busy, 0);
        check("f1_mode_hold", core_mode, 1);
        check("f1_one_alldone", n_ad - ad0, 1);
        nbad = 0;
        for (int i = 0; i < 36; i++)
            if (launch_cyc[i] != t + 2 + (i % 8) + 21 * (i / 8)) nbad++;
        check("f1_launch_sched", nbad, 0);
        check("f1_core8_launch", launch_cyc[8], t + 23);

        // Spurious done on idle core 30
        pulse_start(32'd64, t);
        check("sp_err_before", err_spurious, 0);
        inj_done = '0;
        inj_done[30] = 1'b1;
        @(negedge clk);
        inj_done = '0;
        check("sp_err_set", err_spurious, 1);
        check("sp_done_cnt", done_cnt, 0);
        wait_done0(300, at);
        check("sp_alldone_cyc", at, t + 110);
        check("sp_done_cnt_end", done_cnt, 36);
        check("sp_err_sticky", err_spurious, 1);

        // Three completions in the same cycle as one launch
        hold = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start(32'd64, t);
        check("td_err_clr", err_spurious, 0);
        repeat (11) @(negedge clk);
        check("td_cap", active_cnt, 8);
        check("td_stall", core_start, 0);
        inj_done = 36'h1;
        manual_mask = 36'h1;
        @(negedge clk);
        check("td_one_freed", active_cnt, 7);
        inj_done = 36'hE;
        manual_mask = 36'hF;
        @(negedge clk);
        inj_done = '0;
        check("td_active", active_cnt, 5);
        check("td_launch8", core_start, 36'h100);
        check("td_done_cnt", done_cnt, 4);
        lat = 3;
        hold = 1'b0;
        wait_done0(300, at);
        check("td_completes", at != -1, 1);
        check("td_done_cnt_end", done_cnt, 36);
        check("td_no_spur", err_spurious, 0);
        repeat (2) @(negedge clk);
        manual_mask = '0;

        // Reset in DISPATCH with 5 running, then minimum-latency frame at size 48
        hold = 1'b1;
        pulse_start(32'd64, t);
        repeat (6) @(negedge clk);
        check("ra_active5", active_cnt, 5);
        ad0 = n_ad;
        reset = 1'b1;
        #1;
        check("ra_core_size", core_size, 0);
        check("ra_core_mode", core_mode, 1);
        check("ra_core_start", core_start, 0);
        check("ra_busy", busy, 0);
        check("ra_active", active_cnt, 0);
        check("ra_done_cnt", done_cnt, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold = 1'b0;
        lat = 1;
        check("ra_no_alldone", n_ad - ad0, 0);
        pulse_start(32'd48, t);
        check("ml_size48", core_size, 48);
        check("ml_busy", busy, 1);
        @(negedge clk);
        check("ml_setup_nolaunch", core_start, 0);
        @(negedge clk);
        check("ml_first_core0", core_start, 36'h1);
        wait_done0(100, at);
        check("ml_alldone_cyc", at, t + 39);
        check("ml_done_cnt", done_cnt, 36);

        // MAX_ACTIVE=1 instance: serial launches, ignored restart
        @(negedge clk);
        size1 = 32'd64;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        t = cyc;
        check("s1_busy", busy1, 1);
        repeat (2) @(negedge clk);
        check("s1_first", core_start1, 36'h1);
        @(negedge clk);
        size1 = 32'd40;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("s1_restart_busy", busy1, 1);
        check("s1_restart_size", core_size1, 64);
        check("s1_restart_err", err_size1, 0);
        at = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (all_done1) begin
                at = cyc;
                break;
            end
        end
        check("s1_alldone_cyc", at, t + 74);
        repeat (4) @(negedge clk);
        check("s1_one_alldone", n_ad1, 1);
        check("s1_busy_off", busy1, 0);
        check("s1_launches", n_launch1, 36);
        check("s1_done_cnt", done_cnt1, 36);
        nbad = 0;
        for (int i = 0; i < 35; i++)
            if (launch_cyc1[i + 1] - launch_cyc1[i] != 2) nbad++;
        check("s1_serial", nbad, 0);

        check("never_over_cap", n_over, 0);
        check("onehot_launch", n_multi, 0);
        check("s1_never_over_cap", n_over1, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/face_core_scheduler.md
# face_core_scheduler

Dispatcher for the face-detection manycore array. It accepts one frame request (image side length `size`), validates it, and launches the per-core detectors in index order. No more than `MAX_ACTIVE` cores run at once. The block collects each core's completion pulse and reports frame completion. It sits between the frame loader and the `core_NN` instances, and drives their shared `size`/`mode` inputs.

## Interface
- `NUM_CORES`, 36: number of detector cores (6×6 grid of 3×3-unit tiles).
- `MAX_ACTIVE`, 8: maximum cores running simultaneously; range 1..`NUM_CORES`.
- `ID_W`, 6: width of core index/counters; must hold `NUM_CORES`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `size`  in  32  image side length in pixels; sampled with `start`.
- `core_size`  out  32  registered frame size broadcast to all cores.
- `core_mode`  out  1  0 = cores run, 1 = cores hold.
- `core_start`  out  `NUM_CORES`  one-hot, one-cycle launch pulse per core.
- `core_done`  in  `NUM_CORES`  one-cycle completion pulse per core; multiple bits may be high at once.
- `busy`  out  1  high from accepted `start` through DONE.
- `active_cnt`  out  `ID_W`  number of cores currently running.
- `done_cnt`  out  `ID_W`  number of cores completed in the current frame.
- `all_done`  out  1  one-cycle pulse when every core has completed.
- `err_size`  out  1  sticky; the last request was rejected.
- `err_spurious`  out  1  sticky; a `core_done` arrived from a core that was not running.

## Operation
- Reset values: `core_size`=0, `core_mode`=1, `core_start`=0, `busy`=0, `active_cnt`=0, `done_cnt`=0, `all_done`=0, both err flags 0, `running` vector 0, `next_id`=0, state IDLE.
- Internal state: `running[NUM_CORES-1:0]`, `next_id`, FSM states IDLE, SETUP, DISPATCH, DRAIN, DONE.
- **IDLE**:
  - On `start`=1, clear both err flags and check `size`.
  - `size` is valid when `size[2:0]`==0 and `size` ≥ 48, so that `size/8` ≥ 6.
  - Invalid: set `err_size` and stay in IDLE. No launch occurs.
  - Valid: latch `core_size`, clear `done_cnt` and `next_id`, go to SETUP.
- **SETUP**: one cycle. `core_mode`=0 so the cores load their tiles. Go to DISPATCH.
- **DISPATCH**:
  - Each cycle, if `active_cnt` < `MAX_ACTIVE` (registered value, before this cycle's completions), pulse `core_start[next_id]`, set `running[next_id]`, and increment `next_id`.
  - At most one launch per cycle.
  - When the launch of index `NUM_CORES-1` is issued, go to DRAIN.
- **DRAIN**: no launches. When `running` is all zero and no launch is pending, go to DONE.
- **DONE**: `all_done`=1 for one cycle, then go to IDLE. `busy` and `core_mode` return to 0/1 on entry to IDLE.
- **Completion, every state**:
  - Each `core_done[i]` with `running[i]`=1 clears `running[i]` and increments `done_cnt`.
  - Each `core_done[i]` with `running[i]`=0 sets `err_spurious` and is otherwise ignored.
- `active_cnt` = popcount(`running`), registered.
- A launch and k completions in the same cycle update the count to `active_cnt` + 1 − k.
- A `core_done` on the same index being launched in that cycle counts as spurious. The launch still takes effect.
- `start` while `busy` is ignored.
- Reset mid-frame aborts immediately to the reset values. No `all_done` is issued.

## Timing
- `start` accepted at edge T: `busy`=1, `core_size` valid at T+1 (SETUP). First `core_start` at T+2.
- Launch throughput: one core per cycle until the `MAX_ACTIVE` cap is reached.
- A completion seen at edge E frees a slot. The next launch occurs at E+1.
- `all_done` is asserted exactly one cycle after the edge that clears the last `running` bit.
- Minimum frame latency from `start` to `all_done`: `NUM_CORES` + 3 cycles, assuming zero-latency cores (done the cycle after start).

## Test plan
- Reset mid-DISPATCH with 5 cores running → next cycle all outputs at reset values; a later `start` launches from core 0.
- `size`=40, then `size`=100 → `err_size`=1 each time, no `core_start`, `busy` stays 0. Then `size`=64 → `err_size` clears, `core_size`=64.
- `size`=64, cores complete 20 cycles after launch → `core_start` pulses core 0..7 on consecutive cycles, then `active_cnt` holds at 8. Core 8 launches one cycle after core 0's done. `all_done` fires once, and `done_cnt`=36.
- Three `core_done` bits in the same cycle as one launch → `active_cnt` drops by 2. No launch exceeds 8 active.
- `core_done[30]` pulsed while core 30 is idle → `err_spurious`=1, `done_cnt` unchanged, frame still completes with `done_cnt`=36.
- `MAX_ACTIVE`=1, `start` re-pulsed while `busy` → strictly serial launches, second `start` ignored, exactly one `all_done`.
